// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Decodes the instruction-register opcode and sequences
// fetch / decode / execute / memory / writeback, driving the datapath
// enables and the ALUOp code for the downstream ALU control block.
//
// Ports:
//   clk_i          system clock, all state on rising edge
//   rst_i          synchronous reset, active-low
//   opcode_i       IR[31:26], valid from DECODE onward
//   mem_ready_i    memory completed the current access this cycle
//   PCWrite_o      unconditional PC load
//   PCWriteCond_o  PC load if branch condition holds
//   BranchNe_o     1 = branch on zero == 0 (bne), 0 = on zero == 1 (beq)
//   IorD_o         memory address: 0 = PC, 1 = ALUOut
//   MemRead_o      memory read strobe
//   MemWrite_o     memory write strobe
//   IRWrite_o      instruction register load
//   RegDst_o       write register: 0 = rt, 1 = rd
//   MemtoReg_o     write data: 0 = ALUOut, 1 = MDR
//   RegWrite_o     register file write
//   ALUSrcA_o      0 = PC, 1 = A register
//   ALUSrcB_o      00 = B, 01 = 4, 10 = sext imm, 11 = sext imm << 2
//   ALUOp_o        00 add, 01 sub, 10 use funct
//   PCSource_o     00 = ALU result, 01 = ALUOut, 10 = jump target
//   illegal_o      one-cycle pulse when an undefined opcode is decoded
//   state_o        current state encoding
module multicycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       BranchNe_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       RegDst_o,
  output logic       MemtoReg_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] ALUOp_o,
  output logic [1:0] PCSource_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  state_e state_q, state_d;
  state_e state_eff;

  // Next-state logic; codes 12-15 fall into the default and recover to FETCH.
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:    state_d = mem_ready_i ? StDecode : StFetch;
      StDecode: begin
        case (opcode_i)
          OpLw, OpSw:   state_d = StMemAddr;
          OpRType:      state_d = StExecute;
          OpBeq, OpBne: state_d = StBranch;
          OpJ:          state_d = StJump;
          OpAddi:       state_d = StAddiExec;
          default:      state_d = StFetch;
        endcase
      end
      // Only lw/sw reach MEM_ADDR; the IR keeps the opcode stable here.
      StMemAddr:  state_d = (opcode_i == OpSw) ? StMemWrite : StMemRead;
      StMemRead:  state_d = mem_ready_i ? StMemWb : StMemRead;
      StMemWrite: state_d = mem_ready_i ? StFetch : StMemWrite;
      StExecute:  state_d = StRWb;
      StAddiExec: state_d = StAddiWb;
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

  // While reset is held the outputs look like FETCH with every write enable off.
  assign state_eff = rst_i ? state_q : StFetch;

  always_comb begin
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    BranchNe_o    = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    RegDst_o      = 1'b0;
    MemtoReg_o    = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    ALUOp_o       = 2'b00;
    PCSource_o    = 2'b00;
    illegal_o     = 1'b0;
    case (state_eff)
      StFetch: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        // PC+4 and IR load only on the cycle the fetch completes.
        PCWrite_o = mem_ready_i & rst_i;
        IRWrite_o = mem_ready_i & rst_i;
      end
      StDecode: begin
        ALUSrcB_o = 2'b11;
        case (opcode_i)
          OpRType, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpJ: illegal_o = 1'b0;
          default:                                        illegal_o = 1'b1;
        endcase
      end
      StMemAddr, StAddiExec: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
      end
      StMemRead: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
      end
      StMemWrite: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
      end
      StMemWb: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
      end
      StExecute: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = 2'b10;
      end
      StRWb: begin
        RegWrite_o = 1'b1;
        RegDst_o   = 1'b1;
      end
      StAddiWb: begin
        RegWrite_o = 1'b1;
      end
      StBranch: begin
        ALUSrcA_o     = 1'b1;
        ALUOp_o       = 2'b01;
        PCWriteCond_o = 1'b1;
        PCSource_o    = 2'b01;
        BranchNe_o    = (opcode_i == OpBne);
      end
      StJump: begin
        PCWrite_o  = 1'b1;
        PCSource_o = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction paths are expanded
// into per-cycle (state, mem_ready) lists, the expected control word for
// each cycle comes from the output table, and a compare process checks
// every cycle. Literal state traces pin the path expansion itself.
module tb_multicycle_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [5:0] opcode_i;
  logic       mem_ready_i;
  logic       PCWrite_o, PCWriteCond_o, BranchNe_o, IorD_o, MemRead_o, MemWrite_o;
  logic       IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o, ALUSrcA_o, illegal_o;
  logic [1:0] ALUSrcB_o, ALUOp_o, PCSource_o;
  logic [3:0] state_o;

  always #5 clk_i = ~clk_i;

  multicycle_ctrl dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .opcode_i      (opcode_i),
    .mem_ready_i   (mem_ready_i),
    .PCWrite_o     (PCWrite_o),
    .PCWriteCond_o (PCWriteCond_o),
    .BranchNe_o    (BranchNe_o),
    .IorD_o        (IorD_o),
    .MemRead_o     (MemRead_o),
    .MemWrite_o    (MemWrite_o),
    .IRWrite_o     (IRWrite_o),
    .RegDst_o      (RegDst_o),
    .MemtoReg_o    (MemtoReg_o),
    .RegWrite_o    (RegWrite_o),
    .ALUSrcA_o     (ALUSrcA_o),
    .ALUSrcB_o     (ALUSrcB_o),
    .ALUOp_o       (ALUOp_o),
    .PCSource_o    (PCSource_o),
    .illegal_o     (illegal_o),
    .state_o       (state_o)
  );

  typedef struct packed {
    logic       pcw, pcwc, bne, iord, mr, mw, irw, regdst, m2r, rw, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       ill;
  } ctrl_t;

  ctrl_t act;
  assign act = {PCWrite_o, PCWriteCond_o, BranchNe_o, IorD_o, MemRead_o, MemWrite_o,
                IRWrite_o, RegDst_o, MemtoReg_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o,
                ALUOp_o, PCSource_o, illegal_o};

  int n_cmp = 0;
  int n_bad = 0;

  ctrl_t exp_ctrl;
  int    exp_state;
  logic  exp_chk_state;
  logic  exp_valid = 1'b0;

  int trace_q[$];
  int irw_cnt, rw_cnt, mw_cnt, ill_cnt;

  int   path_st[$];
  logic path_rdy[$];

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Expected control word straight from the per-state output table.
  function automatic ctrl_t spec_ctrl(int st_in, logic rdy, logic [5:0] op, logic rs);
    ctrl_t c;
    int    st;
    c  = '0;
    st = rs ? st_in : 0;
    case (st)
      0: begin c.mr = 1; c.srcb = 2'b01; c.pcw = rdy & rs; c.irw = rdy & rs; end
      1: begin
        c.srcb = 2'b11;
        c.ill  = !(op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02});
      end
      2, 10: begin c.srca = 1; c.srcb = 2'b10; end
      3: begin c.mr = 1; c.iord = 1; end
      4: begin c.rw = 1; c.m2r = 1; end
      5: begin c.mw = 1; c.iord = 1; end
      6: begin c.srca = 1; c.aluop = 2'b10; end
      7: begin c.rw = 1; c.regdst = 1; end
      8: begin
        c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01;
        c.bne = (op == 6'h05);
      end
      9: begin c.pcw = 1; c.pcsrc = 2'b10; end
      11: c.rw = 1;
      default: ;
    endcase
    return c;
  endfunction

  // Compare process: checks outputs mid-cycle and logs the observed trace.
  initial begin
    forever begin
      @(negedge clk_i);
      if (exp_valid) begin
        chk("ctrl", 32'(act), 32'(exp_ctrl));
        if (exp_chk_state) chk("state", 32'(state_o), 32'(exp_state));
        trace_q.push_back(int'(state_o));
        irw_cnt += int'(IRWrite_o);
        rw_cnt  += int'(RegWrite_o);
        mw_cnt  += int'(MemWrite_o);
        ill_cnt += int'(illegal_o);
      end
    end
  end

  task automatic drive(int st, logic rdy, logic [5:0] op, logic rs);
    rst_i         = rs;
    mem_ready_i   = rdy;
    opcode_i      = op;
    exp_ctrl      = spec_ctrl(st, rdy, op, rs);
    exp_state     = st;
    exp_chk_state = rs;
    exp_valid     = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic add(int st, logic rdy);
    path_st.push_back(st);
    path_rdy.push_back(rdy);
  endtask

  task automatic add_mem(int st, int waits);
    for (int i = 0; i < waits; i++) add(st, 1'b0);
    add(st, 1'b1);
  endtask

  task automatic clear_obs();
    trace_q.delete();
    irw_cnt = 0; rw_cnt = 0; mw_cnt = 0; ill_cnt = 0;
  endtask

  // Expand one instruction into its cycle path, then drive it.
  task automatic run_instr(logic [5:0] op, int fw, int mw);
    path_st.delete();
    path_rdy.delete();
    add_mem(0, fw);
    add(1, 1'($urandom_range(1)));
    case (op)
      6'h23: begin add(2, 1'($urandom_range(1))); add_mem(3, mw); add(4, 1'($urandom_range(1))); end
      6'h2B: begin add(2, 1'($urandom_range(1))); add_mem(5, mw); end
      6'h00: begin add(6, 1'($urandom_range(1))); add(7, 1'($urandom_range(1))); end
      6'h04, 6'h05: add(8, 1'($urandom_range(1)));
      6'h02: add(9, 1'($urandom_range(1)));
      6'h08: begin add(10, 1'($urandom_range(1))); add(11, 1'($urandom_range(1))); end
      default: ;
    endcase
    clear_obs();
    // Opcode during FETCH is stale IR content, so drive something unrelated.
    for (int i = 0; i < path_st.size(); i++)
      drive(path_st[i], path_rdy[i], (path_st[i] == 0) ? 6'h3F : op, 1'b1);
  endtask

  task automatic chk_trace(string name, int want[$]);
    chk({name, "_len"}, 32'(trace_q.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < trace_q.size(); i++)
      chk(name, 32'(trace_q[i]), 32'(want[i]));
  endtask

  int lit[$];

  initial begin
    rst_i       = 1'b0;
    mem_ready_i = 1'b0;
    opcode_i    = 6'h00;
    @(posedge clk_i);
    #1;
    // Reset held: FETCH-like outputs, write enables masked even with ready high.
    drive(0, 1'b0, 6'h3F, 1'b0);
    drive(0, 1'b1, 6'h00, 1'b0);

    run_instr(6'h00, 0, 0);
    lit = '{0, 1, 6, 7};
    chk_trace("rtype_trace", lit);
    chk("rtype_regwrite_cnt", 32'(rw_cnt), 32'd1);

    run_instr(6'h23, 2, 3);
    lit = '{0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
    chk_trace("lw_trace", lit);
    chk("lw_irwrite_cnt", 32'(irw_cnt), 32'd1);
    chk("lw_regwrite_cnt", 32'(rw_cnt), 32'd1);

    run_instr(6'h05, 0, 0);
    lit = '{0, 1, 8};
    chk_trace("bne_trace", lit);
    run_instr(6'h04, 1, 0);
    lit = '{0, 0, 1, 8};
    chk_trace("beq_trace", lit);

    run_instr(6'h2B, 0, 0);
    lit = '{0, 1, 2, 5};
    chk_trace("sw_trace", lit);
    chk("sw_memwrite_cnt", 32'(mw_cnt), 32'd1);
    run_instr(6'h02, 0, 0);
    lit = '{0, 1, 9};
    chk_trace("j_trace", lit);

    run_instr(6'h3F, 0, 0);
    lit = '{0, 1};
    chk_trace("ill_trace", lit);
    chk("ill_pulse_cnt", 32'(ill_cnt), 32'd1);
    chk("ill_regwrite_cnt", 32'(rw_cnt), 32'd0);
    chk("ill_memwrite_cnt", 32'(mw_cnt), 32'd0);

    run_instr(6'h08, 1, 0);
    lit = '{0, 0, 1, 10, 11};
    chk_trace("addi_trace", lit);
    run_instr(6'h2B, 0, 2);
    run_instr(6'h01, 0, 0);

    // Reset mid-stall in MEM_READ; ready high on the reset cycle must not win.
    drive(0, 1'b1, 6'h3F, 1'b1);
    drive(1, 1'b0, 6'h23, 1'b1);
    drive(2, 1'b0, 6'h23, 1'b1);
    drive(3, 1'b0, 6'h23, 1'b1);
    drive(3, 1'b0, 6'h23, 1'b1);
    clear_obs();
    drive(3, 1'b1, 6'h23, 1'b0);
    drive(0, 1'b1, 6'h23, 1'b0);
    chk("rst_write_enables", 32'(irw_cnt + rw_cnt + mw_cnt + ill_cnt), 32'd0);
    run_instr(6'h00, 0, 0);
    lit = '{0, 1, 6, 7};
    chk_trace("post_rst_trace", lit);
    run_instr(6'h23, 0, 0);
    drive(0, 1'b0, 6'h3F, 1'b1);

    exp_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
